// File: rtl/alu_arb_pkg.sv
// Shared widths and FSM state type for the
// two-requester ALU arbiter.
package alu_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int SEL_W   = 4;
  localparam int LAT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker: lone request wins,
// on contention ptr names the winner. gnt one-hot.
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (1'b1)
      (req == 2'b11): gnt = ptr ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters.
// Ports: req_* in, rsp_* out, alu_* to/from the ALU.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0][SEL_W-1:0]  req_sel,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DATA_W-1:0]              rsp_out,
  output logic                           rsp_carry,
  output logic [DATA_W-1:0]              alu_a,
  output logic [DATA_W-1:0]              alu_b,
  output logic [SEL_W-1:0]               alu_sel,
  input  logic [DATA_W-1:0]              alu_out,
  input  logic                           alu_carry,
  output logic                           busy
);

  state_e             state_q;
  state_e             state_d;
  logic               prio_q;
  logic               owner_q;
  logic [LAT_W-1:0]   lat_q;
  logic [NUM_REQ-1:0] gnt;
  logic               win;
  logic               xfer;
  logic               rsp_fire;
  logic               lat_last;

  rr_arb2 u_rr (
    .req (req_valid),
    .ptr (prio_q),
    .gnt (gnt)
  );

  assign win       = gnt[1];
  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);
  assign lat_last  = (lat_q == LAT_W'(1));
  assign busy      = (state_q != IDLE);

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  assign rsp_fire = (state_q == RESP) &&
                    rsp_ready[owner_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (xfer)     state_d = WAIT;
      WAIT: if (lat_last) state_d = RESP;
      RESP: if (rsp_fire) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      lat_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && xfer) begin
        alu_a   <= req_a[win];
        alu_b   <= req_b[win];
        alu_sel <= req_sel[win];
        owner_q <= win;
        lat_q   <= LAT_W'(ALU_LAT);
      end
      if (state_q == WAIT) begin
        lat_q <= lat_q - LAT_W'(1);
        if (lat_last) begin
          rsp_out   <= alu_out;
          rsp_carry <= alu_carry;
        end
      end
      // Loser of this round goes first next time.
      if (rsp_fire) begin
        prio_q <= ~owner_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench: two arbiters (ALU_LAT 1 and 3) against a
// timestamp-based transaction model plus literals.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]      rv [2];
  logic [1:0][7:0] ra [2];
  logic [1:0][7:0] rb [2];
  logic [1:0][3:0] rs [2];
  logic [1:0]      rr [2];

  logic [1:0] o_rdy  [2];
  logic [1:0] o_vld  [2];
  logic [7:0] o_out  [2];
  logic       o_cy   [2];
  logic [7:0] o_a    [2];
  logic [7:0] o_b    [2];
  logic [3:0] o_s    [2];
  logic       o_busy [2];
  logic [8:0] alu_r  [2];

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  function automatic logic [8:0] alu_f(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [3:0] s
  );
    case (s)
      4'h0:    alu_f = {1'b0, a} + {1'b0, b};
      4'h1:    alu_f = {1'b0, a} - {1'b0, b};
      4'h2:    alu_f = {1'b0, a & b};
      4'h3:    alu_f = {1'b0, a | b};
      4'h4:    alu_f = {1'b0, a ^ b};
      default: alu_f = {1'b0, a};
    endcase
  endfunction

  assign alu_r[0] = alu_f(o_a[0], o_b[0], o_s[0]);
  assign alu_r[1] = alu_f(o_a[1], o_b[1], o_s[1]);

  alu_arbiter #(.ALU_LAT(1)) dut1 (
    .clock     (clock),
    .reset     (reset),
    .req_valid (rv[0]),
    .req_ready (o_rdy[0]),
    .req_a     (ra[0]),
    .req_b     (rb[0]),
    .req_sel   (rs[0]),
    .rsp_valid (o_vld[0]),
    .rsp_ready (rr[0]),
    .rsp_out   (o_out[0]),
    .rsp_carry (o_cy[0]),
    .alu_a     (o_a[0]),
    .alu_b     (o_b[0]),
    .alu_sel   (o_s[0]),
    .alu_out   (alu_r[0][7:0]),
    .alu_carry (alu_r[0][8]),
    .busy      (o_busy[0])
  );

  alu_arbiter #(.ALU_LAT(3)) dut3 (
    .clock     (clock),
    .reset     (reset),
    .req_valid (rv[1]),
    .req_ready (o_rdy[1]),
    .req_a     (ra[1]),
    .req_b     (rb[1]),
    .req_sel   (rs[1]),
    .rsp_valid (o_vld[1]),
    .rsp_ready (rr[1]),
    .rsp_out   (o_out[1]),
    .rsp_carry (o_cy[1]),
    .alu_a     (o_a[1]),
    .alu_b     (o_b[1]),
    .alu_sel   (o_s[1]),
    .alu_out   (alu_r[1][7:0]),
    .alu_carry (alu_r[1][8]),
    .busy      (o_busy[1])
  );

  task automatic chk(
    input string nm,
    input int    act,
    input int    exp
  );
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(posedge clock) cyc++;

  // Transaction model: a job issued at edge t
  // answers from edge t+LAT until acknowledged.
  bit         m_busy [2];
  bit         m_own  [2];
  bit         m_ptr  [2];
  int         m_iss  [2];
  logic [8:0] m_res  [2];
  logic [7:0] m_a    [2];
  logic [7:0] m_b    [2];
  logic [3:0] m_s    [2];
  int         lat_of [2] = '{1, 3};

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      logic [1:0] win;
      logic [1:0] e_rdy;
      logic [1:0] e_vld;
      string      p;
      p = $sformatf("lat%0d", lat_of[d]);
      if (!reset) begin
        m_busy[d] = 1'b0;
        m_own[d]  = 1'b0;
        m_ptr[d]  = 1'b0;
        m_res[d]  = '0;
        m_a[d]    = '0;
        m_b[d]    = '0;
        m_s[d]    = '0;
      end
      if (rv[d] == 2'b11)
        win = m_ptr[d] ? 2'b10 : 2'b01;
      else
        win = rv[d];
      e_rdy = m_busy[d] ? 2'b00 : win;
      e_vld = 2'b00;
      if (m_busy[d] &&
          cyc - m_iss[d] >= lat_of[d])
        e_vld = m_own[d] ? 2'b10 : 2'b01;
      chk({p, " req_ready"}, o_rdy[d], e_rdy);
      chk({p, " rsp_valid"}, o_vld[d], e_vld);
      chk({p, " busy"}, o_busy[d], m_busy[d]);
      chk({p, " alu_a"}, o_a[d], m_a[d]);
      chk({p, " alu_b"}, o_b[d], m_b[d]);
      chk({p, " alu_sel"}, o_s[d], m_s[d]);
      if (e_vld != 2'b00 || !reset) begin
        chk({p, " rsp_out"}, o_out[d],
            m_res[d][7:0]);
        chk({p, " rsp_carry"}, o_cy[d],
            m_res[d][8]);
      end
      if (reset) begin
        if (m_busy[d]) begin
          if (e_vld != 2'b00 &&
              rr[d][m_own[d]]) begin
            m_busy[d] = 1'b0;
            m_ptr[d]  = ~m_own[d];
          end
        end else if (win != 2'b00) begin
          m_busy[d] = 1'b1;
          m_own[d]  = win[1];
          m_iss[d]  = cyc + 1;
          m_a[d]    = ra[d][win[1]];
          m_b[d]    = rb[d][win[1]];
          m_s[d]    = rs[d][win[1]];
          m_res[d]  = alu_f(m_a[d], m_b[d],
                            m_s[d]);
        end
      end
    end
  end

  initial begin
    int g[$];
    int iss[$];
    int rsp[$];
    bit seen;
    for (int d = 0; d < 2; d++) begin
      rv[d] = '0;
      ra[d] = '0;
      rb[d] = '0;
      rs[d] = '0;
      rr[d] = 2'b11;
    end

    repeat (2) @(negedge clock);
    chk("rst busy", o_busy[0], 0);
    chk("rst rsp_valid", o_vld[0], 0);
    chk("rst alu_sel", o_s[0], 0);

    // Single request, first edge after release.
    tick();
    reset    = 1'b1;
    rv[0]    = 2'b01;
    ra[0][0] = 8'h3C;
    rb[0][0] = 8'h11;
    rs[0][0] = 4'h0;
    tick();
    rv[0] = 2'b00;
    chk("single alu_a", o_a[0], 8'h3C);
    chk("single alu_b", o_b[0], 8'h11);
    tick();
    chk("single rsp_valid", o_vld[0], 2'b01);
    chk("single rsp_out", o_out[0], 8'h4D);
    chk("single rsp_carry", o_cy[0], 0);
    tick();
    chk("single idle", o_busy[0], 0);

    // Contention from reset.
    reset = 1'b0;
    tick();
    tick();
    reset    = 1'b1;
    rv[0]    = 2'b11;
    ra[0][0] = 8'h01;
    rb[0][0] = 8'h02;
    rs[0][0] = 4'h2;
    ra[0][1] = 8'h80;
    rb[0][1] = 8'h05;
    rs[0][1] = 4'hF;
    for (int k = 0; k < 60 && g.size() < 8;
         k++) begin
      @(negedge clock);
      if (o_rdy[0] != 2'b00)
        g.push_back(int'(o_rdy[0][1]));
    end
    tick();
    rv[0] = 2'b00;
    chk("rr grants", g.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("rr grant%0d", k),
          k < g.size() ? g[k] : 2, k % 2);
    repeat (4) tick();

    // Backpressure with carry result.
    rr[0]    = 2'b10;
    rv[0]    = 2'b01;
    ra[0][0] = 8'hFF;
    rb[0][0] = 8'hFF;
    rs[0][0] = 4'h0;
    tick();
    rv[0]    = 2'b10;
    ra[0][1] = 8'h33;
    rb[0][1] = 8'h44;
    rs[0][1] = 4'h4;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      seen = (o_vld[0] != 2'b00);
    end
    chk("bp rsp seen", seen, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("bp rsp_valid", o_vld[0], 2'b01);
      chk("bp rsp_out", o_out[0], 8'hFE);
      chk("bp rsp_carry", o_cy[0], 1);
      chk("bp req_ready", o_rdy[0], 2'b00);
      chk("bp busy", o_busy[0], 1);
    end
    tick();
    rr[0] = 2'b11;
    rv[0] = 2'b00;
    repeat (3) tick();
    chk("bp drop idle", o_busy[0], 0);
    chk("bp alu_a held", o_a[0], 8'hFF);

    // Reset during WAIT aborts the job.
    rv[0]    = 2'b10;
    ra[0][1] = 8'h10;
    rb[0][1] = 8'h20;
    rs[0][1] = 4'h0;
    tick();
    reset = 1'b0;
    rv[0] = 2'b00;
    @(negedge clock);
    chk("rw busy", o_busy[0], 0);
    chk("rw rsp_valid", o_vld[0], 0);
    chk("rw alu_a", o_a[0], 0);
    chk("rw rsp_out", o_out[0], 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("rw no rsp", o_vld[0], 0);
    end

    // ALU_LAT=3 latency and issue interval.
    tick();
    rv[1]    = 2'b01;
    ra[1][0] = 8'h07;
    rb[1][0] = 8'h09;
    rs[1][0] = 4'h1;
    for (int k = 0; k < 40 && rsp.size() < 3;
         k++) begin
      @(negedge clock);
      if (o_rdy[1] != 2'b00) iss.push_back(cyc);
      if (o_vld[1] != 2'b00) rsp.push_back(cyc);
    end
    tick();
    rv[1] = 2'b00;
    chk("lat3 rsp count", rsp.size(), 3);
    if (iss.size() >= 2 && rsp.size() >= 2) begin
      chk("lat3 delay0", rsp[0] - iss[0], 4);
      chk("lat3 delay1", rsp[1] - iss[1], 4);
      chk("lat3 interval", iss[1] - iss[0], 5);
    end else begin
      chk("lat3 samples", iss.size(), 2);
    end
    chk("lat3 rsp_out", o_out[1], 8'hFE);
    chk("lat3 rsp_carry", o_cy[1], 1);

    repeat (6) tick();
    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
